// File: rtl/arb_pkg.sv
// Shared definitions for the packet round-robin arbiter: source count, FSM
// encodings and the round-robin pick function.
package arb_pkg;

    localparam int N_SRC = 4;
    localparam int ID_W  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Rotate so the source after 'last' sits at bit 0, take the lowest set
    // bit, then rotate the index back into source numbering.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                                input logic [ID_W-1:0]  last);
        logic [2*N_SRC-1:0] dbl;
        logic [N_SRC-1:0]   rot;
        logic [ID_W-1:0]    start;
        logic [ID_W-1:0]    off;
        start = last + 2'd1;
        dbl   = {req, req};
        rot   = dbl[start +: N_SRC];
        off   = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (rot[k]) off = k[ID_W-1:0];
        end
        return start + off;
    endfunction

endpackage

// File: rtl/axis_skid2.sv
// Two-entry skid buffer. in_ready is a register, so nothing combinational
// runs from out_ready back to in_ready.
module axis_skid2 #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [1:0]   cnt_p0;
    logic         rdy_p0;
    logic [W-1:0] ent0_p1;
    logic [W-1:0] ent1_p1;
    logic         push;
    logic         pop;
    logic [1:0]   cnt_nxt;

    assign push = in_valid & rdy_p0;
    assign pop  = (cnt_p0 != 2'd0) & out_ready;

    always_comb begin
        cnt_nxt = cnt_p0;
        if (push && !pop)
            cnt_nxt = cnt_p0 + 2'd1;
        else if (!push && pop)
            cnt_nxt = cnt_p0 - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0 <= 2'd0;
            rdy_p0 <= 1'b1;
        end else begin
            cnt_p0 <= cnt_nxt;
            rdy_p0 <= (cnt_nxt != 2'd2);
        end
    end

    // ---- entry storage (ent0 is always the head) ----
    always_ff @(posedge clk) begin
        if (pop) begin
            if (cnt_p0 == 2'd2)
                ent0_p1 <= ent1_p1;
            else if (push)
                ent0_p1 <= in_data;
        end else if (push) begin
            if (cnt_p0 == 2'd0)
                ent0_p1 <= in_data;
            else
                ent1_p1 <= in_data;
        end
    end

    assign in_ready  = rdy_p0;
    assign out_valid = (cnt_p0 != 2'd0);
    assign out_data  = out_valid ? ent0_p1 : '0;

endmodule

// File: rtl/pkt_rr_arb.sv
// Packet-granular round-robin arbiter merging four AXI-Stream sources.
// Optional per-source grant counters are built when GRANT_CNT_EN is defined.
module pkt_rr_arb
    import arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_SRC*DATA_WIDTH-1:0] src_TDATA,
    input  logic [N_SRC-1:0]            src_TVALID,
    output logic [N_SRC-1:0]            src_TREADY,
    input  logic [N_SRC-1:0]            src_TLAST,
    output logic [DATA_WIDTH-1:0]       res_TDATA,
    output logic                        res_TVALID,
    input  logic                        res_TREADY,
    output logic                        res_TLAST,
    output logic [ID_W-1:0]             res_TID
`ifdef GRANT_CNT_EN
    ,
    output logic [N_SRC*CNT_WIDTH-1:0]  grant_cnt
`endif
);

    localparam int SKID_W = DATA_WIDTH + 1 + ID_W;

    arb_state_t              state_p0;
    logic [ID_W-1:0]         grant_p0;
    logic [ID_W-1:0]         last_p0;
    logic [ID_W-1:0]         pick;
    logic                    skid_in_ready;
    logic                    beat_vld;
    logic                    beat_push;
    logic                    beat_last;
    logic [DATA_WIDTH-1:0]   beat_data;
    logic [SKID_W-1:0]       skid_out;

    assign pick      = rr_pick(src_TVALID, last_p0);
    assign beat_data = src_TDATA[grant_p0*DATA_WIDTH +: DATA_WIDTH];
    assign beat_last = src_TLAST[grant_p0];
    assign beat_vld  = (state_p0 == ST_BUSY) & src_TVALID[grant_p0];
    assign beat_push = beat_vld & skid_in_ready;

    always_comb begin
        src_TREADY = '0;
        if (state_p0 == ST_BUSY)
            src_TREADY[grant_p0] = skid_in_ready;
    end

    // ---- arbitration FSM: grant held from first beat through TLAST ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= ST_IDLE;
            grant_p0 <= '0;
            last_p0  <= ID_W'(N_SRC - 1);
        end else begin
            case (state_p0)
                ST_IDLE: begin
                    if (|src_TVALID) begin
                        grant_p0 <= pick;
                        state_p0 <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (beat_push && beat_last) begin
                        last_p0  <= grant_p0;
                        state_p0 <= ST_IDLE;
                    end
                end
                default: state_p0 <= ST_IDLE;
            endcase
        end
    end

    // ---- output stage: beats tagged with their source index ----
    axis_skid2 #(
        .W(SKID_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  ({grant_p0, beat_last, beat_data}),
        .in_valid (beat_vld),
        .in_ready (skid_in_ready),
        .out_data (skid_out),
        .out_valid(res_TVALID),
        .out_ready(res_TREADY)
    );

    assign res_TID   = skid_out[SKID_W-1 -: ID_W];
    assign res_TLAST = skid_out[DATA_WIDTH];
    assign res_TDATA = skid_out[DATA_WIDTH-1:0];

`ifdef GRANT_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_p0 [N_SRC];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) cnt_p0[i] <= '0;
        end else if (state_p0 == ST_IDLE && |src_TVALID) begin
            cnt_p0[pick] <= cnt_p0[pick] + 1'b1;
        end
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_cnt_out
        assign grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_p0[g];
    end
`else
    // Counters are absent; CNT_WIDTH is still range-checked for consistency.
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("CNT_WIDTH must be at least 1");
    end
`endif

endmodule
